// File: rtl/flash_fetch_line_buffer.sv
// flash_fetch_line_buffer: one-line read buffer that refills from the flash controller FIFO on a miss
module flash_fetch_line_buffer #(
    parameter int CHUNK_DEPTH    = 16,
    parameter int REQ_HOLD       = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [23:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    input  logic        invalidate,
    output logic        read_chunk,
    output logic [23:0] address_wp,
    output logic [7:0]  numByte_read_wp,
    output logic        rden,
    input  logic [7:0]  buf_out,
    input  logic        buf_empty,
    input  logic        buf_full
);
    localparam int LB = $clog2(CHUNK_DEPTH);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FLUSH, RESP} state_t;
    state_t          state;
    logic [7:0]      line [CHUNK_DEPTH];
    logic [23-LB:0]  tag;
    logic            line_valid, inv_pend, pend, err, hit;
    logic [7:0]      hold;
    logic [15:0]     tmo;
    logic [LB:0]     cnt;
    logic            unused;
    assign unused = ^cpu_addr[1:0];
    assign numByte_read_wp = 8'(CHUNK_DEPTH);
    assign hit = line_valid && !invalidate && tag == cpu_addr[23:LB];
    always_ff @(posedge clk)
        if (state == DRAIN && pend) line[cnt[LB-1:0]] <= buf_out;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tag        <= '0;
            line_valid <= 1'b0;
            inv_pend   <= 1'b0;
            pend       <= 1'b0;
            err        <= 1'b0;
            hold       <= '0;
            tmo        <= '0;
            cnt        <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            cpu_err    <= 1'b0;
            read_chunk <= 1'b0;
            rden       <= 1'b0;
            address_wp <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            rden      <= 1'b0;
            if (invalidate && (state == REQ || state == WAIT || state == DRAIN)) inv_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (invalidate) line_valid <= 1'b0;
                    // cpu_req is still high during the ready cycle; ignore it there
                    if (cpu_req && !cpu_ready) begin
                        if (hit) begin
                            state <= RESP;
                            err   <= 1'b0;
                        end else begin
                            state      <= REQ;
                            read_chunk <= 1'b1;
                            hold       <= '0;
                            address_wp <= {cpu_addr[23:LB], {LB{1'b0}}};
                            line_valid <= 1'b0;
                            inv_pend   <= 1'b0;
                            err        <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    hold <= hold + 8'd1;
                    if (hold == 8'(REQ_HOLD - 1)) begin
                        read_chunk <= 1'b0;
                        tmo        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    tmo <= &tmo ? tmo : tmo + 16'd1;
                    if (buf_full) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        pend  <= 1'b0;
                    end else if (tmo == 16'(TIMEOUT_CYCLES - 1)) state <= FLUSH;
                end
                DRAIN: begin
                    // rden cycle -> byte-valid cycle (stored above) -> next strobe
                    if (rden) pend <= 1'b1;
                    else if (pend) begin
                        pend <= 1'b0;
                        cnt  <= cnt + 1'b1;
                    end else if (cnt[LB]) begin
                        tag        <= address_wp[23:LB];
                        line_valid <= !(inv_pend || invalidate);
                        state      <= RESP;
                    end else if (!buf_empty) rden <= 1'b1;
                end
                FLUSH: begin
                    if (!rden) begin
                        if (!buf_empty) rden <= 1'b1;
                        else begin
                            err        <= 1'b1;
                            line_valid <= 1'b0;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    cpu_err   <= err;
                    cpu_rdata <= {line[{cpu_addr[LB-1:2], 2'd3}], line[{cpu_addr[LB-1:2], 2'd2}],
                                  line[{cpu_addr[LB-1:2], 2'd1}], line[{cpu_addr[LB-1:2], 2'd0}]};
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
